// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops plus iterative
// unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             zero_signal,
    output logic             div_by_zero
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SRA   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_BEQ   = 4'b1010;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MULTU = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1110;
    localparam logic [3:0] OP_PASS  = 4'b1111;

    // Iterations occupy counts 0..WIDTH-1; the extra count publishes the result.
    localparam logic [SHW:0] ITER_LAST = (SHW+1)'(WIDTH);

    logic [1:0]       state;
    logic [SHW:0]     count;
    logic             is_mul;
    logic             dbz_pend;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;

    logic [WIDTH-1:0] single_res;
    logic             single_zero;
    logic             is_multi;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_trial;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign is_multi  = (alu_control == OP_MULTU) || (alu_control == OP_DIVU);

    always_comb begin
        single_res = '0;
        case (alu_control)
            OP_AND:  single_res = in_1 & in_2;
            OP_OR:   single_res = in_1 | in_2;
            OP_ADD:  single_res = in_1 + in_2;
            OP_SUB:  single_res = in_1 - in_2;
            OP_SLL:  single_res = in_1 << shamt;
            OP_SRL:  single_res = in_1 >> shamt;
            OP_SRA:  single_res = $unsigned($signed(in_1) >>> shamt);
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(in_1) < $signed(in_2))};
            OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (in_1 < in_2)};
            OP_NOR:  single_res = ~(in_1 | in_2);
            OP_PASS: single_res = in_1;
            default: single_res = '0;
        endcase
        single_zero = (alu_control == OP_BEQ) ? (in_1 == in_2) : (single_res == '0);
    end

    // hi_reg/lo_reg hold {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_reg} : {(WIDTH+1){1'b0}});
        rem_shift = {hi_reg, lo_reg[WIDTH-1]};
        rem_trial = rem_shift - {1'b0, a_reg};
        if (is_mul) begin
            iter_hi = mul_sum[WIDTH:1];
            iter_lo = {mul_sum[0], lo_reg[WIDTH-1:1]};
        end else if (rem_trial[WIDTH]) begin
            iter_hi = rem_shift[WIDTH-1:0];
            iter_lo = {lo_reg[WIDTH-2:0], 1'b0};
        end else begin
            iter_hi = rem_trial[WIDTH-1:0];
            iter_lo = {lo_reg[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            count       <= '0;
            is_mul      <= 1'b0;
            dbz_pend    <= 1'b0;
            a_reg       <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            out         <= '0;
            out_hi      <= '0;
            zero_signal <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (is_multi) begin
                            state    <= ST_BUSY;
                            count    <= '0;
                            is_mul   <= (alu_control == OP_MULTU);
                            dbz_pend <= (alu_control == OP_DIVU) && (in_2 == '0);
                            hi_reg   <= '0;
                            a_reg    <= (alu_control == OP_MULTU) ? in_1 : in_2;
                            lo_reg   <= (alu_control == OP_MULTU) ? in_2 : in_1;
                        end else begin
                            state       <= ST_DONE;
                            out         <= single_res;
                            out_hi      <= '0;
                            zero_signal <= single_zero;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (count == ITER_LAST) begin
                        state       <= ST_DONE;
                        count       <= '0;
                        out         <= lo_reg;
                        out_hi      <= hi_reg;
                        zero_signal <= (lo_reg == '0);
                        div_by_zero <= dbz_pend;
                    end else begin
                        hi_reg <= iter_hi;
                        lo_reg <= iter_lo;
                        count  <= count + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
